sr_input_conditioner: RTL and testbench

- Upstream stage for the team's clocked set/reset flip-flop.
- Takes two raw, asynchronous pushbutton inputs (set, reset), synchronizes and debounces each, and emits clean single-cycle s/r pulses that the flip-flop consumes directly.
- Also exposes debounced levels and a conflict flag for same-cycle set/reset events.

---
 rtl/sr_pkg.sv | 14 +
 rtl/sr_debounce_chan.sv | 46 ++++
 rtl/sr_input_conditioner.sv | 77 +++++++
 tb/tb_sr_input_conditioner.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared defaults, counter-width helper and conflict priority for sr_input_conditioner
package sr_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int SYNC_STAGES_DEF     = 2;

  // When both channels rise on the same edge, reset takes the pulse.
  localparam bit RESET_WINS = 1'b1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_debounce_chan.sv
// rtl/sr_debounce_chan.sv - one button channel: synchronizer, debounce counter, level and rise detect
module sr_debounce_chan
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;
  logic                   flip;

  assign synced = sync[SYNC_STAGES-1];
  assign flip   = (synced != level) && (cnt == LAST);
  // Combinational on purpose: the top registers it on the same edge the level toggles.
  assign rise   = flip & ~level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (synced == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_input_conditioner.sv
// rtl/sr_input_conditioner.sv - set/reset button conditioner top; optional set_count under SR_EVENT_CNT_EN
module sr_input_conditioner
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_raw,
  input  logic       rst_raw,
  output logic       s_out,
  output logic       r_out,
  output logic       s_level,
  output logic       r_level,
  output logic       conflict
`ifdef SR_EVENT_CNT_EN
  ,
  output logic [7:0] set_count
`endif
);

  logic set_rise;
  logic rst_rise;
  logic s_next;
  logic r_next;

  sr_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_set (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (set_raw),
    .level (s_level),
    .rise  (set_rise)
  );

  sr_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (rst_raw),
    .level (r_level),
    .rise  (rst_rise)
  );

  always_comb begin
    s_next = set_rise;
    r_next = rst_rise;
    if (RESET_WINS) begin
      s_next = set_rise & ~rst_rise;
    end else begin
      r_next = rst_rise & ~set_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s_out    <= s_next;
      r_out    <= r_next;
      conflict <= set_rise & rst_rise;
    end
  end

`ifdef SR_EVENT_CNT_EN
  // Counts only pulses that reach s_out, so arbitrated-away sets are excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_count <= 8'd0;
    end else if (s_next && (set_count != 8'hFF)) begin
      set_count <= set_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb/tb_sr_input_conditioner.sv - randomized self-checking bench for sr_input_conditioner
module tb_sr_input_conditioner;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_raw = 1'b0;
  logic rst_raw = 1'b0;
  logic s_out, r_out, s_level, r_level, conflict;
`ifdef SR_EVENT_CNT_EN
  logic [7:0] set_count;
`endif

  sr_input_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_raw  (set_raw),
    .rst_raw  (rst_raw),
    .s_out    (s_out),
    .r_out    (r_out),
    .s_level  (s_level),
    .r_level  (r_level),
    .conflict (conflict)
`ifdef SR_EVENT_CNT_EN
    ,
    .set_count(set_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw samples per edge since reset release; a level flips when the
  // last D synchronized samples all disagree with it and D edges have passed since its last flip.
  bit sam_s [0:8191];
  bit sam_r [0:8191];
  int ec;
  bit ml_s, ml_r, e_s, e_r, e_c;
  int lf_s, lf_r;
  int m_cnt;

  task automatic model_clear();
    ec = 0; ml_s = 0; ml_r = 0; e_s = 0; e_r = 0; e_c = 0;
    lf_s = -1000; lf_r = -1000; m_cnt = 0;
  endtask

  function automatic bit flip_due(input int t, input bit lvl, input int lf, input bit is_set);
    bit v;
    if (t < lf + D) return 1'b0;
    for (int k = t - D - S + 1; k <= t - S; k++) begin
      v = (k < 0) ? 1'b0 : (is_set ? sam_s[k] : sam_r[k]);
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit fs, fr, rs, rr;
    sam_s[ec] = set_raw;
    sam_r[ec] = rst_raw;
    fs = flip_due(ec, ml_s, lf_s, 1'b1);
    fr = flip_due(ec, ml_r, lf_r, 1'b0);
    rs = fs && !ml_s;
    rr = fr && !ml_r;
    e_s = rs && !rr;
    e_r = rr;
    e_c = rs && rr;
    if (fs) begin ml_s = !ml_s; lf_s = ec; end
    if (fr) begin ml_r = !ml_r; lf_r = ec; end
    if (e_s && m_cnt < 255) m_cnt++;
    ec++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {s_out, r_out, s_level, r_level, conflict};
  endfunction

  function automatic logic [4:0] expv();
    return {e_s, e_r, ml_s, ml_r, e_c};
  endfunction

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (outs() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", outs());
    end
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int ns = 0, nr = 0, nc = 0, c_edge = -1;
    set_raw = 1'b1; rst_raw = 1'b1;
    apply_reset(3);
    for (int i = 0; i < 14; i++) begin
      tick();
      n_checks++;
      if (outs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %b want %b", ec - 1, outs(), expv());
      end
      ns += s_out; nr += r_out;
      if (conflict) begin nc++; c_edge = ec - 1; end
    end
    n_checks++;
    if (ns !== 0 || nr !== 1 || nc !== 1 || c_edge !== S - 1 + D) begin
      n_fail++;
      $display("FAIL reset_held_pulses: got s=%0d r=%0d c=%0d at %0d want s=0 r=1 c=1 at %0d",
               ns, nr, nc, c_edge, S - 1 + D);
    end
  endtask

  task automatic test_clean_press();
    int ns = 0, nr = 0, s_edge = -1, press;
    set_raw = 1'b0; rst_raw = 1'b0;
    apply_reset(2);
    repeat (5) tick();
    set_raw = 1'b1;
    press = ec;
    for (int i = 0; i < 32; i++) begin
      if (i == 20) set_raw = 1'b0;
      tick();
      n_checks++;
      if (outs() !== expv()) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got %b want %b", ec - 1, outs(), expv());
      end
      ns += s_out; nr += r_out;
      if (s_out) s_edge = ec - 1;
    end
    n_checks++;
    if (ns !== 1 || nr !== 0 || s_edge !== press + S - 1 + D) begin
      n_fail++;
      $display("FAIL clean_press_pulse: got s=%0d r=%0d at %0d want s=1 r=0 at %0d",
               ns, nr, s_edge, press + S - 1 + D);
    end
  endtask

  task automatic test_glitch();
    int ns = 0, nl = 0;
    set_raw = 1'b0; rst_raw = 1'b0;
    apply_reset(2);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      set_raw = (i < D - 1);
      tick();
      n_checks++;
      if (outs() !== expv()) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got %b want %b", ec - 1, outs(), expv());
      end
      ns += s_out; nl += s_level;
    end
    n_checks++;
    if (ns !== 0 || nl !== 0) begin
      n_fail++;
      $display("FAIL glitch_rejected: got pulses=%0d level_cycles=%0d want 0 0", ns, nl);
    end
  endtask

  task automatic test_bounce();
    int ns = 0, s_edge = -1, hold = -1;
    set_raw = 1'b0; rst_raw = 1'b0;
    apply_reset(2);
    repeat (3) tick();
    for (int i = 0; i < 32; i++) begin
      if (i < 5) set_raw = ~i[0];
      else if (i < 20) set_raw = 1'b1;
      else set_raw = 1'b0;
      if (i == 4) hold = ec;
      tick();
      n_checks++;
      if (outs() !== expv()) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got %b want %b", ec - 1, outs(), expv());
      end
      ns += s_out;
      if (s_out) s_edge = ec - 1;
    end
    n_checks++;
    if (ns !== 1 || s_edge !== hold + S - 1 + D) begin
      n_fail++;
      $display("FAIL bounce_single_pulse: got %0d at %0d want 1 at %0d", ns, s_edge, hold + S - 1 + D);
    end
  endtask

  task automatic test_conflict();
    int ns = 0, nr = 0, nc = 0, c_edge = -1, press;
    set_raw = 1'b0; rst_raw = 1'b0;
    apply_reset(2);
    repeat (4) tick();
    set_raw = 1'b1; rst_raw = 1'b1;
    press = ec;
    for (int i = 0; i < 28; i++) begin
      if (i == 15) begin set_raw = 1'b0; rst_raw = 1'b0; end
      tick();
      n_checks++;
      if (outs() !== expv()) begin
        n_fail++;
        $display("FAIL conflict edge %0d: got %b want %b", ec - 1, outs(), expv());
      end
      ns += s_out; nr += r_out;
      if (conflict) begin nc++; c_edge = ec - 1; end
    end
    n_checks++;
    if (ns !== 0 || nr !== 1 || nc !== 1 || c_edge !== press + S - 1 + D) begin
      n_fail++;
      $display("FAIL conflict_reset_wins: got s=%0d r=%0d c=%0d at %0d want 0 1 1 at %0d",
               ns, nr, nc, c_edge, press + S - 1 + D);
    end
`ifdef SR_EVENT_CNT_EN
    n_checks++;
    if (set_count !== 8'd0) begin
      n_fail++;
      $display("FAIL conflict_set_count: got %0d want 0", set_count);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int ns = 0, s_edge = -1;
    set_raw = 1'b0; rst_raw = 1'b0;
    apply_reset(2);
    set_raw = 1'b1;
    for (int i = 0; i < S + 2; i++) begin
      tick();
      ns += s_out;
    end
    apply_reset(2);
    for (int i = 0; i < 14; i++) begin
      tick();
      n_checks++;
      if (outs() !== expv()) begin
        n_fail++;
        $display("FAIL mid_reset edge %0d: got %b want %b", ec - 1, outs(), expv());
      end
      ns += s_out;
      if (s_out) s_edge = ec - 1;
    end
    n_checks++;
    if (ns !== 1 || s_edge !== S - 1 + D) begin
      n_fail++;
      $display("FAIL mid_reset_pulse: got %0d at %0d want 1 at %0d", ns, s_edge, S - 1 + D);
    end
  endtask

  task automatic test_random();
    int hs = 0, hr = 0;
    set_raw = 1'b0; rst_raw = 1'b0;
    apply_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if (hs == 0) begin set_raw = $urandom_range(0, 1); hs = $urandom_range(1, 12); end
      if (hr == 0) begin rst_raw = $urandom_range(0, 1); hr = $urandom_range(1, 12); end
      hs--; hr--;
      tick();
      n_checks++;
      if (outs() !== expv()) begin
        n_fail++;
        $display("FAIL random edge %0d: got %b want %b", ec - 1, outs(), expv());
      end
`ifdef SR_EVENT_CNT_EN
      n_checks++;
      if (set_count !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL random_set_count edge %0d: got %0d want %0d", ec - 1, set_count, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_conflict();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
